// File: rtl/single_port_sync_ram.sv
// Single-port synchronous RAM with a shared tri-state data bus, chip select, write and output enable.
// Read latency is 1 cycle (registered rdata). There is no backpressure: one access per cycle at full rate.
module single_port_sync_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_drive;

    assign w_wr_en = cs & we;
    assign w_rd_en = cs & ~we;

    // The driver is also gated by rst so the bus is released for the whole reset pulse.
    assign w_drive = w_rd_en & oe & ~rst;
    assign data    = w_drive ? r_rdata : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[addr] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rd_en) begin
            r_rdata <= r_mem[addr];
        end
    end

endmodule

// File: tb/tb_single_port_sync_ram.sv
// Directed bench for single_port_sync_ram: reset, fill/readback, chip select, output enable and bus release.
module tb_single_port_sync_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  addr = '0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic        oe = 1'b0;
    logic        host_en = 1'b0;
    logic [15:0] host_dat = '0;
    wire  [15:0] data;

    int total = 0;
    int bad   = 0;
    logic [15:0] vals [16];

    assign data = host_en ? host_dat : 16'hzzzz;

    always #5 clk = ~clk;

    single_port_sync_ram #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(16),
        .DEPTH     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .addr(addr),
        .data(data),
        .cs  (cs),
        .we  (we),
        .oe  (oe)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp);
        total++;
        assert (data === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, data, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        cs = 1'b1; we = 1'b1; oe = 1'b0; addr = a;
        host_en = 1'b1; host_dat = d;
        step();
        host_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        host_en = 1'b0;
        cs = 1'b1; we = 1'b0; oe = 1'b1; addr = a;
        step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            vals[i] = 16'($urandom_range(0, 16'hFFFF));
        end

        // Bus released during power-on reset: host probe value shows through.
        cs = 1'b1; we = 1'b0; oe = 1'b1;
        host_en = 1'b1; host_dat = 16'h5A5A;
        #3;
        chk("rst_bus_release", 16'h5A5A);
        host_en = 1'b0; cs = 1'b0; oe = 1'b0;
        step();
        rst = 1'b0;
        step();

        rd(4'd3);
        chk("por_mem_zero", 16'h0000);

        // Mid-simulation reset clears a written word and rdata.
        wr(4'd3, 16'hBEEF);
        rd(4'd3);
        chk("pre_rst_read", 16'hBEEF);
        #2;
        rst = 1'b1;
        host_en = 1'b1; host_dat = 16'h4110;
        #1;
        chk("mid_rst_release", 16'h4110);
        step();
        host_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("rdata_cleared", 16'h0000);
        rd(4'd3);
        chk("mem3_cleared", 16'h0000);

        // Fill then read back on consecutive edges.
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), vals[i]);
        end
        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
            chk($sformatf("readback_%0d", i), vals[i]);
        end

        // Chip select off blocks a write and releases the bus.
        wr(4'd5, 16'h1234);
        cs = 1'b0; we = 1'b1; oe = 1'b0; addr = 4'd5;
        host_en = 1'b1; host_dat = 16'hFFFF;
        step();
        we = 1'b0; oe = 1'b1; host_dat = 16'h6C6C;
        #1;
        chk("cs0_bus_release", 16'h6C6C);
        host_en = 1'b0;
        rd(4'd5);
        chk("cs0_no_write", 16'h1234);
        rd(4'd5);
        chk("nondestructive", 16'h1234);

        // cs=0 edge holds rdata even with a different address.
        cs = 1'b0; addr = 4'd0;
        step();
        cs = 1'b1;
        #1;
        chk("cs0_rdata_hold", 16'h1234);

        // Output enable gating: rdata loads while bus stays released.
        rd(4'd0);
        chk("read_addr0", vals[0]);
        cs = 1'b1; we = 1'b0; oe = 1'b0; addr = 4'd5;
        host_en = 1'b1; host_dat = 16'hEDCB;
        step();
        chk("oe0_release", 16'hEDCB);
        host_en = 1'b0;
        oe = 1'b1;
        #1;
        chk("oe_raise_comb", 16'h1234);

        // Write then read the same address; other writes leave it alone.
        wr(4'd15, 16'hA5A5);
        rd(4'd15);
        chk("wr_then_rd_15", 16'hA5A5);

        // Bus release during a write with oe=1: host value stored, no contention.
        cs = 1'b1; we = 1'b1; oe = 1'b1; addr = 4'd0;
        host_en = 1'b1; host_dat = 16'h0F0F;
        #1;
        chk("wr_oe1_no_drive", 16'h0F0F);
        step();
        host_en = 1'b0;
        rd(4'd0);
        chk("wr_oe1_stored", 16'h0F0F);
        rd(4'd15);
        chk("addr15_intact", 16'hA5A5);
        rd(4'd7);
        chk("addr7_intact", vals[7]);

        cs = 1'b0; oe = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
